// File: rtl/inst_mem_wait.sv
// inst_mem_wait: instruction memory with fetch handshake, wait states, stall hold, flush and fault reporting
module inst_mem_wait #(
  parameter int    XLEN      = 32,
  parameter int    DEPTH     = 64,
  parameter int    WAIT      = 0,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault,
  input  logic            flush,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t          r_state, w_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic [31:0]     r_addr, w_rd_addr;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_data;
  logic            r_fault, w_ld_we, w_accept, w_load, w_fault;
`ifdef IMEM_LOAD_PORT_EN
  assign w_ld_we = ld_we;
`else
  logic w_unused;
  assign w_ld_we  = 1'b0;
  assign w_unused = ^{ld_we, ld_addr, ld_data};
`endif
  assign req_ready = ~flush & ~w_ld_we & (r_state == S_IDLE | (r_state == S_RESP & rsp_ready));
  assign w_accept  = req_valid & req_ready;
  assign w_rd_addr = r_state == S_WAIT ? r_addr : req_addr;
  assign w_fault   = (w_rd_addr[1:0] != 2'b00) | ({2'b00, w_rd_addr[31:2]} >= 32'(DEPTH));
  assign w_load    = (w_accept && WAIT == 0) || (!flush && r_state == S_WAIT && r_cnt == 4'd0);
  assign rsp_valid = r_state == S_RESP;
  assign rsp_data  = r_data;
  assign rsp_fault = r_fault;
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (flush) begin
      w_next     = S_IDLE;
      w_cnt_next = 4'd0;
    end else if (w_accept) begin
      w_next     = WAIT == 0 ? S_RESP : S_WAIT;
      w_cnt_next = 4'(WAIT);
    end else if (r_state == S_WAIT) begin
      w_next     = r_cnt == 4'd0 ? S_RESP : S_WAIT;
      w_cnt_next = r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1;
    end else if (r_state == S_RESP && rsp_ready) begin
      w_next     = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_fault <= 1'b0;
      r_data  <= NOP;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) r_addr <= req_addr;
      if (w_load) begin
        r_fault <= w_fault;
        r_data  <= w_fault ? NOP : r_mem[w_rd_addr[AW+1:2]];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_ld_we) r_mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_inst_mem_wait.sv
// tb_inst_mem_wait: scoreboard bench over three instances with WAIT = 0, 2 and 3.
module tb_inst_mem_wait;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, flush;
   logic [31:0] req_addr [3];
   logic [31:0] rsp_data [3];
   logic        ld_we;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;
   logic [31:0] mdl [64];
   int          n_tot = 0;
   int          n_bad = 0;
   localparam int WV [3] = '{0, 2, 3};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inst_mem_wait #(.WAIT(WV[g])) u_dut (
         .clk(clk), .rst(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
         .rsp_fault(rsp_fault[g]), .flush(flush[g]),
         .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] exp_of(input logic [31:0] a);
      if (a[1:0] != 2'b00 || a[31:2] >= 30'd64) return {1'b1, 32'h00000013};
      return {1'b0, mdl[a[7:2]]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_mon
      logic [32:0] q [$];
      always @(negedge clk) begin
         if (rst) q.delete();
         else begin
            if (q.size() == 0) check("spur", 64'(rsp_valid[g]), 64'd0);
            else if (rsp_valid[g] && rsp_ready[g]) begin
               check("data", 64'(rsp_data[g]), 64'(q[0][31:0]));
               check("flt", 64'(rsp_fault[g]), 64'(q[0][32]));
               void'(q.pop_front());
            end
            if (flush[g]) q.delete();
            if (req_valid[g] && req_ready[g]) q.push_back(exp_of(req_addr[g]));
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; req_valid = '0; rsp_ready = '1; flush = '0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      for (int g = 0; g < 3; g++) req_addr[g] = '0;
      for (int i = 0; i < 64; i++) mdl[i] = $urandom;
      mdl[0] = 32'h00002E37; mdl[1] = 32'h00002E17; mdl[2] = 32'h00100F93; mdl[5] = 32'h11111111;
`ifdef IMEM_LOAD_PORT_EN
      for (int i = 0; i < 64; i++) begin
         ld_we = 1'b1; ld_addr = 6'(i); ld_data = mdl[i];
         tick();
      end
      ld_we = 1'b0;
`else
      for (int i = 0; i < 64; i++) begin
         g_dut[0].u_dut.r_mem[i] = mdl[i];
         g_dut[1].u_dut.r_mem[i] = mdl[i];
         g_dut[2].u_dut.r_mem[i] = mdl[i];
      end
`endif
      tick(); tick();
      for (int g = 0; g < 3; g++) begin
         check("rst_v", 64'(rsp_valid[g]), 64'd0);
         check("rst_f", 64'(rsp_fault[g]), 64'd0);
         check("rst_d", 64'(rsp_data[g]), 64'h13);
      end
      rst = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) check("rst_rdy", 64'(req_ready[g]), 64'd1);
      // back-to-back fetches at one per cycle
      for (int k = 0; k < 3; k++) begin
         req_valid[0] = 1'b1; req_addr[0] = 32'(k * 4);
         tick();
         check("b2b_v", 64'(rsp_valid[0]), 64'd1);
      end
      req_valid[0] = 1'b0;
      tick();
      check("b2b_idle", 64'(rsp_valid[0]), 64'd0);
      // WAIT=2 latency and a 4-cycle consumer stall
      rsp_ready[1] = 1'b0; req_valid[1] = 1'b1; req_addr[1] = 32'h4;
      tick();
      req_valid[1] = 1'b0;
      check("lat0", 64'(rsp_valid[1]), 64'd0);
      for (int j = 1; j <= 3; j++) begin
         tick();
         check("lat", 64'(rsp_valid[1]), 64'(j == 3));
      end
      req_valid[1] = 1'b1; req_addr[1] = 32'h8;
      for (int j = 0; j < 4; j++) begin
         tick();
         check("stl_v", 64'(rsp_valid[1]), 64'd1);
         check("stl_d", 64'(rsp_data[1]), 64'(mdl[1]));
         check("stl_rdy", 64'(req_ready[1]), 64'd0);
      end
      req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
      tick();
      check("stl_end", 64'(rsp_valid[1]), 64'd0);
      // faults, including the last valid word and out-of-range words
      req_valid[0] = 1'b1;
      foreach (WV[j]) begin end
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: req_addr[0] = 32'h2;
            1: req_addr[0] = 32'h100;
            2: req_addr[0] = 32'hFC;
            3: req_addr[0] = 32'hFFFFFFFC;
            default: req_addr[0] = 32'h1;
         endcase
         tick();
      end
      req_valid[0] = 1'b0;
      tick();
      check("flt_idle", 64'(rsp_valid[0]), 64'd0);
      // flush on the 2nd wait cycle with a competing request
      req_valid[2] = 1'b1; req_addr[2] = 32'hC;
      tick();
      req_valid[2] = 1'b0;
      tick();
      flush[2] = 1'b1; req_valid[2] = 1'b1; req_addr[2] = 32'h10;
      #1;
      check("fl_rdy", 64'(req_ready[2]), 64'd0);
      tick();
      flush[2] = 1'b0; req_valid[2] = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         check("fl_v", 64'(rsp_valid[2]), 64'd0);
      end
      req_valid[2] = 1'b1;
      tick();
      req_valid[2] = 1'b0;
      n = 0;
      while (!rsp_valid[2] && n < 20) begin
         tick();
         n++;
      end
      check("fl_lat", 64'(n), 64'd4);
      tick();
      // load port write, competing with a fetch of the same word
      ld_we = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEADBEEF;
      req_valid[0] = 1'b1; req_addr[0] = 32'h14;
      #1;
`ifdef IMEM_LOAD_PORT_EN
      check("ld_blk", 64'(req_ready[0]), 64'd0);
`else
      check("ld_blk", 64'(req_ready[0]), 64'd1);
`endif
      tick();
      ld_we = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
      mdl[5] = 32'hDEADBEEF;
`endif
      tick();
      req_valid[0] = 1'b0;
      tick(); tick();
      // reset in the middle of a fetch
      req_valid[1] = 1'b1; req_addr[1] = 32'h0;
      tick();
      req_valid[1] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("rst_mid_v", 64'(rsp_valid[1]), 64'd0);
      check("rst_mid_d", 64'(rsp_data[1]), 64'h13);
      rst = 1'b0;
      for (int j = 0; j < 6; j++) tick();
      check("sb0", 64'(g_mon[0].q.size()), 64'd0);
      check("sb1", 64'(g_mon[1].q.size()), 64'd0);
      check("sb2", 64'(g_mon[2].q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
